// File: rtl/layer7_loop_ctrl.sv
// Layer-7 convolution loop-nest sequencer: walks (u, x, y, k) with k innermost, tracks datapath latency for write-back.
// Taps issue one per cycle when not stalled; the latency shift register free-runs so stall never delays write-back.
module layer7_loop_ctrl #(
   parameter int X_LAST    = 14,
   parameter int Y_LAST    = 14,
   parameter int U_LAST    = 4,
   parameter int K_LAST    = 8,
   parameter int DRAIN_CYC = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       stall,
   output logic [4:0] x,
   output logic [4:0] y,
   output logic [2:0] u,
   output logic [3:0] k,
   output logic       tap_valid,
   output logic       acc_first,
   output logic       acc_last,
   output logic       wb_valid,
   output logic       busy,
   output logic       done
);

   localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t               state_q;
   logic [4:0]           x_q, y_q;
   logic [2:0]           u_q;
   logic [3:0]           k_q;
   logic [CW-1:0]        cnt_q;
   logic [DRAIN_CYC-1:0] wb_sr_q, wb_sr_d;

   logic k_end, y_end, x_end, u_end;

   assign k_end = (k_q == 4'(K_LAST));
   assign y_end = (y_q == 5'(Y_LAST));
   assign x_end = (x_q == 5'(X_LAST));
   assign u_end = (u_q == 3'(U_LAST));

   assign tap_valid = (state_q == RUN) && !stall;
   assign acc_first = tap_valid && (k_q == 4'd0);
   assign acc_last  = tap_valid && k_end;
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign wb_valid  = wb_sr_q[DRAIN_CYC-1];

   assign x = x_q;
   assign y = y_q;
   assign u = u_q;
   assign k = k_q;

   // Shift form works for DRAIN_CYC == 1 too, where no lower slice exists.
   assign wb_sr_d = (wb_sr_q << 1) | DRAIN_CYC'(acc_last);

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         u_q     <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         wb_sr_q <= '0;
      end else begin
         wb_sr_q <= wb_sr_d;
         case (state_q)
            IDLE: begin
               if (start) state_q <= RUN;
            end
            RUN: begin
               if (!stall) begin
                  if (!k_end) begin
                     k_q <= k_q + 4'd1;
                  end else begin
                     k_q <= '0;
                     if (!y_end) begin
                        y_q <= y_q + 5'd1;
                     end else begin
                        y_q <= '0;
                        if (!x_end) begin
                           x_q <= x_q + 5'd1;
                        end else begin
                           x_q <= '0;
                           if (!u_end) begin
                              u_q <= u_q + 3'd1;
                           end else begin
                              u_q     <= '0;
                              cnt_q   <= '0;
                              state_q <= DRAIN;
                           end
                        end
                     end
                  end
               end
            end
            DRAIN: begin
               if (cnt_q == CW'(DRAIN_CYC - 1)) state_q <= DONE;
               else                             cnt_q   <= cnt_q + 1'b1;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_layer7_loop_ctrl.sv
// Bench for layer7_loop_ctrl: small-config instance checked cycle by cycle against a tap-number model, plus a default-config full pass.
module tb_layer7_loop_ctrl;
   localparam int XL = 1, YL = 2, UL = 1, KL = 1, D = 3;
   localparam int NT = (UL + 1) * (XL + 1) * (YL + 1) * (KL + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, stall;
   logic [4:0] s_x, s_y;
   logic [2:0] s_u;
   logic [3:0] s_k;
   logic       s_tap, s_first, s_last, s_wb, s_busy, s_done;

   logic       rst_b, start_b;
   logic [4:0] b_x, b_y;
   logic [2:0] b_u;
   logic [3:0] b_k;
   logic       b_tap, b_first, b_last, b_wb, b_busy, b_done;

   layer7_loop_ctrl #(.X_LAST(XL), .Y_LAST(YL), .U_LAST(UL), .K_LAST(KL), .DRAIN_CYC(D)) dut_s (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .stall(stall),
      .x(s_x), .y(s_y), .u(s_u), .k(s_k),
      .tap_valid(s_tap), .acc_first(s_first), .acc_last(s_last), .wb_valid(s_wb),
      .busy(s_busy), .done(s_done));

   layer7_loop_ctrl dut_b (
      .clk(clk), .rst(rst_b), .start(start_b), .abort(1'b0), .stall(1'b0),
      .x(b_x), .y(b_y), .u(b_u), .k(b_k),
      .tap_valid(b_tap), .acc_first(b_first), .acc_last(b_last), .wb_valid(b_wb),
      .busy(b_busy), .done(b_done));

   int n_chk = 0, n_fail = 0;
   int cyc = 0;

   // Reference model: tap number n in the current pass, cycle of the final tap, pending acc_last cycles.
   bit m_run = 0;
   int m_n = 0;
   int m_tfin = -1;
   int m_lastq[$];

   int c_tap, c_first, c_last, c_wb, c_done, c_done_cyc, c_last_cyc, c_start_cyc;
   int b_n = 0, b_first_n = 0, b_last_n = 0, b_wb_n = 0, b_done_n = 0;
   bit b_start_req = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [16:0] idx_of(input int n, input int kl, input int yl, input int xl);
      int kk, yy, xx, uu;
      kk = n % (kl + 1);
      yy = (n / (kl + 1)) % (yl + 1);
      xx = (n / ((kl + 1) * (yl + 1))) % (xl + 1);
      uu = n / ((kl + 1) * (yl + 1) * (xl + 1));
      return {xx[4:0], yy[4:0], uu[2:0], kk[3:0]};
   endfunction

   task automatic clr();
      c_tap = 0; c_first = 0; c_last = 0; c_wb = 0; c_done = 0;
      c_done_cyc = -1; c_last_cyc = -1;
   endtask

   task automatic step(input bit st, input bit ab, input bit sl, input bit rs);
      bit e_busy, e_tap, e_wb, e_done;
      int e_k;
      logic [16:0] e_idx;
      @(negedge clk);
      start = st; abort = ab; stall = sl; rst = rs;
      start_b = b_start_req;
      #1;
      e_busy = m_run || (m_tfin >= 0 && cyc <= m_tfin + D + 1);
      e_done = (m_tfin >= 0 && cyc == m_tfin + D + 1);
      e_tap  = m_run && !sl;
      e_k    = m_run ? (m_n % (KL + 1)) : 0;
      e_idx  = m_run ? idx_of(m_n, KL, YL, XL) : 17'd0;
      e_wb   = (m_lastq.size() > 0 && m_lastq[0] == cyc - D);
      if (e_wb) void'(m_lastq.pop_front());
      chk("tap_valid", s_tap, e_tap);
      chk("acc_first", s_first, e_tap && e_k == 0);
      chk("acc_last", s_last, e_tap && e_k == KL);
      chk("wb_valid", s_wb, e_wb);
      chk("busy", s_busy, e_busy);
      chk("done", s_done, e_done);
      chk("indices", {s_x, s_y, s_u, s_k}, e_idx);
      if (s_tap) c_tap++;
      if (s_first) c_first++;
      if (s_last) begin c_last++; c_last_cyc = cyc; end
      if (s_wb) c_wb++;
      if (s_done) begin c_done++; c_done_cyc = cyc; end
      if (b_tap === 1'b1) begin
         chk("b_indices", {b_x, b_y, b_u, b_k}, idx_of(b_n, 8, 14, 14));
         b_n++;
      end
      if (b_first === 1'b1) b_first_n++;
      if (b_last === 1'b1) b_last_n++;
      if (b_wb === 1'b1) b_wb_n++;
      if (b_done === 1'b1) b_done_n++;
      if (rs || ab) begin
         m_run = 0; m_n = 0; m_tfin = -1; m_lastq.delete();
      end else begin
         if (e_tap) begin
            if (e_k == KL) m_lastq.push_back(cyc);
            if (m_n == NT - 1) begin m_run = 0; m_tfin = cyc; end
            else m_n++;
         end
         if (!e_busy && st) begin m_run = 1; m_n = 0; end
      end
      if (m_tfin >= 0 && cyc + 1 > m_tfin + D + 1) m_tfin = -1;
      cyc++;
   endtask

   // One pass: optional stall of stall_len cycles at tap stall_at, optional abort at tap abort_at.
   task automatic run_pass(input int stall_at, input int stall_len, input int abort_at, input int ncyc);
      int sc;
      bit sl, ab;
      sc = 0;
      c_start_cyc = cyc;
      step(1, 0, 0, 0);
      for (int i = 0; i < ncyc; i++) begin
         sl = m_run && m_n == stall_at && sc < stall_len;
         if (sl) sc++;
         ab = m_run && m_n == abort_at;
         step(0, ab, sl, 0);
         if (ab) return;
      end
   endtask

   initial begin
      rst = 1; start = 0; abort = 0; stall = 0;
      rst_b = 1; start_b = 0;
      repeat (2) @(posedge clk);
      cyc = 0;
      clr();
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      // Clean pass
      clr();
      run_pass(-1, 0, -1, 35);
      chk("p1_taps", c_tap, NT);
      chk("p1_first", c_first, NT / (KL + 1));
      chk("p1_last", c_last, NT / (KL + 1));
      chk("p1_wb", c_wb, NT / (KL + 1));
      chk("p1_done", c_done, 1);
      chk("p1_done_lat", c_done_cyc - c_last_cyc, D + 1);
      chk("p1_done_abs", c_done_cyc - c_start_cyc, NT + D + 1);

      // Two-cycle stall at tap 5
      clr();
      run_pass(5, 2, -1, 38);
      chk("p2_taps", c_tap, NT);
      chk("p2_done_abs", c_done_cyc - c_start_cyc, NT + D + 1 + 2);

      // Stall on the final tap
      clr();
      run_pass(NT - 1, 3, -1, 38);
      chk("p3_last", c_last, NT / (KL + 1));
      chk("p3_done_abs", c_done_cyc - c_start_cyc, NT + D + 1 + 3);

      // Abort at tap 10, restart the following cycle
      clr();
      run_pass(-1, 0, 10, 30);
      run_pass(-1, 0, -1, 35);
      chk("p4_taps", c_tap, 11 + NT);
      chk("p4_wb", c_wb, 4 + NT / (KL + 1));
      chk("p4_done", c_done, 1);

      // start+abort in IDLE, then start mid-run
      clr();
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      chk("p5_idle_busy", s_busy, 0);
      c_start_cyc = cyc;
      step(1, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("p5_busy_hold", s_busy, 1);
      for (int i = 0; i < 30; i++) step(0, 0, 0, 0);
      chk("p5_taps", c_tap, NT);
      chk("p5_done", c_done, 1);

      // Randomized stall, start and abort traffic
      for (int p = 0; p < 6; p++) begin
         step(1, 0, 0, 0);
         for (int i = 0; i < 60; i++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, 0);
      end

      // rst during DRAIN
      clr();
      step(1, 0, 0, 0);
      for (int i = 0; i < 100 && !(m_tfin >= 0 && cyc == m_tfin + 2); i++) step(0, 0, 0, 0);
      chk("p6_in_drain", (m_tfin >= 0 && cyc == m_tfin + 2), 1);
      step(0, 0, 0, 1);
      rst_b = 0;
      clr();
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
      chk("p6_no_done", c_done, 0);
      chk("p6_no_wb", c_wb, 0);

      // Default configuration full pass
      b_start_req = 1;
      step(0, 0, 0, 0);
      b_start_req = 0;
      for (int i = 0; i < 10200 && !(b_done_n > 0 && b_busy === 1'b0); i++) step(0, 0, 0, 0);
      chk("b_taps", b_n, 10125);
      chk("b_first", b_first_n, 1125);
      chk("b_last", b_last_n, 1125);
      chk("b_wb", b_wb_n, 1125);
      chk("b_done", b_done_n, 1);
      chk("b_busy_end", b_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
